program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter_pkg.sv | 15 +
 rtl/program_counter_register_w.sv | 29 ++
 rtl/program_counter.sv | 71 +++++++
 tb/tb_program_counter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// Shared constants for the program counter: default width and the
// all-ones / all-zero patterns used by the wrap detector.
package program_counter_pkg;

  localparam int unsigned PC_WIDTH = 16;

  // Fill bits replicated to any WIDTH, so parameterised instances share them.
  localparam logic PC_FILL_ONE  = 1'b1;
  localparam logic PC_FILL_ZERO = 1'b0;

  // Default-width terminal values.
  localparam logic [PC_WIDTH-1:0] PC_ALL_ONES = {PC_WIDTH{PC_FILL_ONE}};
  localparam logic [PC_WIDTH-1:0] PC_ZERO     = {PC_WIDTH{PC_FILL_ZERO}};

endpackage : program_counter_pkg

// File: rtl/program_counter_register_w.sv
// WIDTH-bit storage register with load enable, async active-low reset to 0.
// Ports: clk, rst_n, en_i (capture d_i on this edge), d_i (next value),
//        q_o (stored value).
module register_w
  import program_counter_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Storage flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {WIDTH{PC_FILL_ZERO}};
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : register_w

// File: rtl/program_counter.sv
// Loadable, clearable up-counter with a registered wrap pulse.
// Ports: clk, rst_n (async active-low), in (load value), load, inc,
//        clr (synchronous clear), out (current count), wrap (one-cycle
//        pulse after an increment from all-ones to zero).
// Action priority per edge: clr, then load, then inc, then hold.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{PC_FILL_ONE}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{PC_FILL_ZERO}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             count_en;
  logic             wrap_d;
  logic             wrap_q;

  register_w #(
    .WIDTH (WIDTH)
  ) u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (count_en),
    .d_i   (count_d),
    .q_o   (count_q)
  );

  // Next-value priority mux, incrementer and wrap detector.
  always_comb begin
    count_d  = count_q;
    count_en = 1'b0;
    wrap_d   = 1'b0;
    if (clr) begin
      count_d  = ZERO;
      count_en = 1'b1;
    end else if (load) begin
      count_d  = in;
      count_en = 1'b1;
    end else if (inc) begin
      // Carry out of the top bit is dropped; wrap flags that case instead.
      count_d  = count_q + WIDTH'(1);
      count_en = 1'b1;
      wrap_d   = (count_q == ALL_ONES);
    end
  end

  // Wrap pulse flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign out  = count_q;
  assign wrap = wrap_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Bench for program_counter: a 16-bit and a 4-bit instance share stimulus;
// a behavioural model tracks both and is compared every negative clock edge,
// with directed sequences pinning literal expected values.
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic [15:0] in16;
  logic        load;
  logic        inc;
  logic        clr;
  logic [15:0] out16;
  logic        wrap16;
  logic [3:0]  out4;
  logic        wrap4;

  int n_checks;
  int n_errors;
  bit cmp_en;

  // Behavioural model state.
  int unsigned m16;
  int unsigned m4;
  bit          mw16;
  bit          mw4;

  program_counter #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in16),
    .load  (load),
    .inc   (inc),
    .clr   (clr),
    .out   (out16),
    .wrap  (wrap16)
  );

  program_counter #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in16[3:0]),
    .load  (load),
    .inc   (inc),
    .clr   (clr),
    .out   (out4),
    .wrap  (wrap4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one action per edge by priority; a counter of modulus M.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16 = 0; m4 = 0; mw16 = 0; mw4 = 0;
    end else if (clr) begin
      m16 = 0; m4 = 0; mw16 = 0; mw4 = 0;
    end else if (load) begin
      m16 = int'(in16); m4 = int'(in16) % 16; mw16 = 0; mw4 = 0;
    end else if (inc) begin
      mw16 = (m16 == 65535);
      mw4  = (m4 == 15);
      m16  = (m16 + 1) % 65536;
      m4   = (m4 + 1) % 16;
    end else begin
      mw16 = 0; mw4 = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_out16",  32'(out16),  m16);
      check("model_wrap16", 32'(wrap16), 32'(mw16));
      check("model_out4",   32'(out4),   m4);
      check("model_wrap4",  32'(wrap4),  32'(mw4));
    end
  end

  // Drive controls for the next edge, then land 1ns after that edge.
  task automatic apply(input bit c, input bit l, input bit i, input logic [15:0] v);
    clr = c; load = l; inc = i; in16 = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cmp_en = 0;
    clr = 0; load = 0; inc = 0; in16 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1;

    // Reset holds with load asserted.
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 0, 16'h1234);
      check("reset_out", 32'(out16), 32'h0);
      check("reset_wrap", 32'(wrap16), 32'h0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) apply(0, 0, 1, 16'h0);
    check("after_reset_inc5", 32'(out16), 32'h5);
    check("after_reset_inc5_w4", 32'(out4), 32'h5);

    // Priority.
    apply(0, 1, 0, 16'h0007);
    check("prio_load7", 32'(out16), 32'h7);
    apply(1, 1, 1, 16'hBEEF);
    check("prio_clr", 32'(out16), 32'h0);
    apply(0, 1, 1, 16'hBEEF);
    check("prio_load", 32'(out16), 32'hBEEF);
    apply(0, 0, 1, 16'hBEEF);
    check("prio_inc", 32'(out16), 32'hBEF0);

    // Wrap around.
    apply(0, 1, 0, 16'hFFFE);
    apply(0, 0, 1, 16'h0);
    check("wrap_ffff", 32'(out16), 32'hFFFF);
    check("wrap_ffff_w", 32'(wrap16), 32'h0);
    apply(0, 0, 1, 16'h0);
    check("wrap_0000", 32'(out16), 32'h0);
    check("wrap_0000_w", 32'(wrap16), 32'h1);
    apply(0, 0, 1, 16'h0);
    check("wrap_0001", 32'(out16), 32'h1);
    check("wrap_0001_w", 32'(wrap16), 32'h0);

    // Loading terminal values never wraps.
    apply(0, 1, 0, 16'hFFFF);
    check("load_ffff_w", 32'(wrap16), 32'h0);
    apply(0, 1, 0, 16'h0000);
    check("load_0000_w", 32'(wrap16), 32'h0);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 16'h5A5A);
      check("hold_out", 32'(out16), 32'h0);
      check("hold_w", 32'(wrap16), 32'h0);
    end

    // Async reset mid-count.
    apply(0, 1, 0, 16'h0040);
    apply(0, 0, 1, 16'h0);
    apply(0, 0, 1, 16'h0);
    check("count_42", 32'(out16), 32'h42);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out16), 32'h0);
    check("async_rst_w", 32'(wrap16), 32'h0);
    @(posedge clk);
    #1;
    check("rst_ignores_edge", 32'(out16), 32'h0);
    rst_n = 1'b1;
    apply(0, 0, 1, 16'h0);
    apply(0, 0, 1, 16'h0);
    check("restart_2", 32'(out16), 32'h2);

    // Randomised run against the model.
    for (int k = 0; k < 10000; k++) begin
      logic [15:0] v;
      int sel;
      sel = int'($urandom_range(0, 7));
      v = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'hFFFD :
          (sel == 2) ? 16'h000E : 16'($urandom);
      apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), v);
      if ($urandom_range(0, 511) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_program_counter
